// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block geometry, occupancy states and the
// row-shift permutations used by the encryption and decryption stages.
package aes_pkg;

    localparam int unsigned NB      = 4;
    localparam int unsigned WORD    = 8;
    localparam int unsigned BLOCK_W = NB * NB * WORD;

    // Element [NB*NB-1] is byte b0 (bits [127:120]); byte bi lives at [NB*NB-1-i].
    typedef logic [NB*NB-1:0][WORD-1:0] state_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } occ_e;

    // S'[r][c] = S[r][(c - r) mod NB]
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] blk);
        state_t s;
        state_t d;
        s = blk;
        d = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            for (int unsigned r = 0; r < NB; r++) begin
                d[NB*NB-1-(NB*c+r)] = s[NB*NB-1-(NB*((c+NB-r)%NB)+r)];
            end
        end
        return d;
    endfunction

    // S'[r][c] = S[r][(c + r) mod NB]
    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] blk);
        state_t s;
        state_t d;
        s = blk;
        d = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            for (int unsigned r = 0; r < NB; r++) begin
                d[NB*NB-1-(NB*c+r)] = s[NB*NB-1-(NB*((c+r)%NB)+r)];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/aes_fifo2.sv
// Generic 2-entry valid/ready buffer with a registered in_ready, so there is
// no combinational path from out_ready back to in_ready.
module aes_fifo2
    import aes_pkg::*;
#(
    parameter int unsigned W = 132
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_e         occ;
    occ_e         occ_nxt;
    logic         wr_ptr;
    logic         rd_ptr;
    logic [W-1:0] mem [2];
    logic         push;
    logic         pop;

    assign out_valid = (occ != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        occ_nxt = occ;
        case (occ)
            EMPTY:   if (push) occ_nxt = ONE;
            ONE: begin
                if (push && !pop)      occ_nxt = FULL;
                else if (!push && pop) occ_nxt = EMPTY;
            end
            FULL:    if (pop) occ_nxt = ONE;
            default: occ_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            occ      <= occ_nxt;
            in_ready <= (occ_nxt != FULL);
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule

// File: rtl/inv_shiftrows_stage.sv
// AES decryption InvShiftRows stage: permutes the state on the write side of a
// 2-entry valid/ready buffer and carries a sideband tag alongside each block.
module inv_shiftrows_stage #(
    parameter int unsigned NB    = 4,
    parameter int unsigned WORD  = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [NB*NB*WORD-1:0]  i_block,
    input  logic [TAG_W-1:0]       i_tag,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [NB*NB*WORD-1:0]  o_block,
    output logic [TAG_W-1:0]       o_tag
);

    import aes_pkg::*;

    localparam int unsigned DW = BLOCK_W + TAG_W;

    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    assign wr_data = {inv_shift_rows(i_block), i_tag};

    aes_fifo2 #(
        .W(DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (i_valid),
        .in_ready  (i_ready),
        .in_data   (wr_data),
        .out_valid (o_valid),
        .out_ready (o_ready),
        .out_data  (rd_data)
    );

    assign o_block = rd_data[DW-1 -: BLOCK_W];
    assign o_tag   = rd_data[TAG_W-1:0];

endmodule

// File: tb/tb_inv_shiftrows_stage.sv
// Scoreboard bench for inv_shiftrows_stage: directed vectors, backpressure,
// streaming latency, random handshake traffic and asynchronous reset.
module tb_inv_shiftrows_stage;

    import aes_pkg::*;

    localparam int unsigned PERM [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    typedef struct {
        logic [127:0] blk;
        logic [3:0]   tag;
        int unsigned  cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         i_valid;
    logic         i_ready;
    logic [127:0] i_block;
    logic [3:0]   i_tag;
    logic         o_valid;
    logic         o_ready;
    logic [127:0] o_block;
    logic [3:0]   o_tag;

    int unsigned  n_tests;
    int unsigned  n_fail;
    int unsigned  n_pop;
    int unsigned  cyc;
    logic         chk_lat;
    logic         rand_mode;
    exp_t         sb [$];

    inv_shiftrows_stage #(
        .NB(4),
        .WORD(8),
        .TAG_W(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_block (i_block),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_block (o_block),
        .o_tag   (o_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] ref_inv(input logic [127:0] x);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = x[127-8*PERM[i] -: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pops are evaluated before pushes so a same-cycle push never satisfies its own pop.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 132'd1, 132'd0);
                end else begin
                    e = sb.pop_front();
                    check("o_block", {4'h0, o_block}, {4'h0, e.blk});
                    check("o_tag", {128'h0, o_tag}, {128'h0, e.tag});
                    if (chk_lat) check("latency", 132'(cyc - e.cyc), 132'd1);
                    n_pop++;
                end
            end
            if (!o_valid) check("idle_zero", {o_block, o_tag}, 132'd0);
            if (i_valid && i_ready) sb.push_back('{ref_inv(i_block), i_tag, cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) o_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [127:0] blk, input logic [3:0] tag);
        logic acc;
        int   n;
        i_valid = 1'b1;
        i_block = blk;
        i_tag   = tag;
        n = 0;
        do begin
            @(negedge clk);
            acc = i_ready;
            step();
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 132'd0, 132'd1);
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_block = '0;
        i_tag   = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] x;
        int unsigned  c0;
        int unsigned  n;
        n_tests = 0; n_fail = 0; n_pop = 0; cyc = 0;
        chk_lat = 1'b0; rand_mode = 1'b0;
        rst_n = 1'b0; i_valid = 1'b0; i_block = '0; i_tag = '0; o_ready = 1'b0;

        #23;
        check("rst_o_valid", 132'(o_valid), 132'd0);
        check("rst_o_data", {o_block, o_tag}, 132'd0);
        check("rst_i_ready", 132'(i_ready), 132'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("i_ready_pre_edge", 132'(i_ready), 132'd0);
        @(posedge clk); #1;
        check("i_ready_rise", 132'(i_ready), 132'd1);

        // FIPS-197 vector
        o_ready = 1'b1;
        send(128'h7ad5fda789ef4e272bca100b3d9ff59f, 4'd3);
        idle();
        @(negedge clk);
        check("fips_valid", 132'(o_valid), 132'd1);
        check("fips_block", {4'h0, o_block}, {4'h0, 128'h7a9f102789d5f50b2beffd9f3dca4ea7});
        check("fips_tag", 132'(o_tag), 132'd3);
        step();

        // Index pattern
        send(128'h000102030405060708090a0b0c0d0e0f, 4'd5);
        idle();
        @(negedge clk);
        check("idx_block", {4'h0, o_block}, {4'h0, 128'h000d0a0704010e0b0805020f0c090603});
        step(); step();

        // Backpressure: two accepted, third held
        o_ready = 1'b0;
        send(128'h11111111222222223333333344444444, 4'd1);
        send(128'h55555555666666667777777788888888, 4'd2);
        i_valid = 1'b1;
        i_block = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
        i_tag   = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_i_ready", 132'(i_ready), 132'd0);
            check("bp_head", {4'h0, o_block}, {4'h0, ref_inv(128'h11111111222222223333333344444444)});
            step();
        end
        check("bp_sb_depth", 132'(sb.size()), 132'd2);
        o_ready = 1'b1;
        send(128'h99999999aaaaaaaabbbbbbbbcccccccc, 4'd3);
        idle();
        step(); step();
        check("bp_drained", 132'(sb.size()), 132'd0);
        check("bp_i_ready_back", 132'(i_ready), 132'd1);

        // Streaming: 20 blocks, one per cycle, latency 1
        chk_lat = 1'b1;
        c0 = cyc;
        n  = n_pop;
        for (int k = 0; k < 20; k++) begin
            send({4{$urandom()}}, 4'(k));
        end
        check("stream_no_stall", 132'(cyc - c0), 132'd20);
        idle();
        step(); step();
        chk_lat = 1'b0;
        check("stream_pops", 132'(n_pop - n), 132'd20);

        // Round trip of the package permutations
        for (int k = 0; k < 4; k++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            check("roundtrip", {4'h0, shift_rows(inv_shift_rows(x))}, {4'h0, x});
        end

        // Random handshake traffic
        rand_mode = 1'b1;
        n = n_pop;
        for (int k = 0; k < 1000; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                idle();
                step();
            end
            send({$urandom(), $urandom(), $urandom(), $urandom()}, 4'($urandom()));
        end
        idle();
        rand_mode = 1'b0;
        o_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        check("rand_drained", 132'(sb.size()), 132'd0);
        check("rand_pops", 132'(n_pop - n), 132'd1000);

        // Asynchronous reset while FULL
        o_ready = 1'b0;
        send(128'hdeadbeefdeadbeefdeadbeefdeadbeef, 4'hA);
        send(128'hcafef00dcafef00dcafef00dcafef00d, 4'hB);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_o_valid", 132'(o_valid), 132'd0);
        check("arst_o_data", {o_block, o_tag}, 132'd0);
        check("arst_i_ready", 132'(i_ready), 132'd0);
        sb.delete();
        step();
        rst_n = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);
        check("arst_i_ready_pre", 132'(i_ready), 132'd0);
        step();
        check("arst_i_ready_rise", 132'(i_ready), 132'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("arst_no_stale", 132'(o_valid), 132'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_shiftrows_stage.md
# inv_shiftrows_stage

Decryption-path stage that applies the AES InvShiftRows transform to a 128-bit state and registers the result. It is the inverse of the encryption ShiftRows stage and sits between the inverse-round key-add and InvSubBytes stages of the AES decryption datapath. Unlike the encryption stage, it supports full valid/ready backpressure through a 2-entry output buffer. It carries an opaque sideband tag (round/last marker) alongside each block.

## Interface
- NB, 4, state columns (state is NB x NB bytes; only 4 supported)
- WORD, 8, bits per state byte
- TAG_W, 4, sideband tag width, passed through unmodified
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input block valid
- i_ready  out  1  stage can accept a block this cycle
- i_block  in  NB*NB*WORD  input state, column-major, byte b0 in bits [127:120] through b15 in [7:0]; b(4c+r) = S[r,c]
- i_tag  in  TAG_W  sideband accompanying i_block
- o_valid  out  1  output block valid
- o_ready  in  1  downstream accepts output this cycle
- o_block  out  NB*NB*WORD  InvShiftRows(i_block), same byte ordering
- o_tag  out  TAG_W  tag of the block on o_block

## Operation
- Transform: S'[r][c] = S[r][(c - r) mod 4].
- Flattened output: {b0,b13,b10,b7, b4,b1,b14,b11, b8,b5,b2,b15, b12,b9,b6,b3}.
- Transform is applied at write time; buffer entries hold transformed data.
- Push = i_valid & i_ready. Pop = o_valid & o_ready.
- Buffer is 2 entries with 1-bit write and read pointers that wrap 1 -> 0.
- Occupancy state machine:
  - EMPTY: push -> ONE.
  - ONE: push & pop -> ONE; push only -> FULL; pop only -> EMPTY.
  - FULL: pop -> ONE. Push is impossible because i_ready = 0.
- o_valid = (state != EMPTY). o_block and o_tag come from the head entry and are forced to 0 while o_valid = 0.
- i_ready is a flop: next value = (next_state != FULL). There is no combinational path from o_ready to i_ready.
- Order is strictly FIFO. Blocks are never dropped or duplicated.
- Once o_valid is high, o_block and o_tag hold stable until popped.

## Timing
- Reset (rst_n low, asynchronous): state = EMPTY, pointers = 0, entries = 0, o_valid = 0, o_block = 0, o_tag = 0, i_ready = 0.
- i_ready rises on the first clk edge after rst_n deasserts.
- Reset mid-operation discards all buffered blocks immediately, with no further outputs.
- Latency is 1 cycle: a block pushed at edge N is presented with o_valid = 1 after edge N.
- Throughput is 1 block/cycle while o_ready is held high (steady state ONE).
- With o_ready low, at most 2 blocks are accepted; i_ready drops the cycle after the second push.
- Simultaneous push and pop in ONE: the head advances to the new block and occupancy stays 1.
- In FULL, i_valid is ignored. Upstream must hold i_block and i_tag until accepted.

## Structure
- Shared package aes_pkg holds:
  - NB, WORD and BLOCK_W = NB*NB*WORD
  - typedef state_t as a byte array
  - typedef occ_e {EMPTY, ONE, FULL}
  - function inv_shift_rows(block) returning the permuted block; the encryption stage should later use a matching shift_rows function.
- One sub-module is natural: aes_fifo2, a generic 2-entry valid/ready buffer of width BLOCK_W+TAG_W with registered in_ready. inv_shiftrows_stage wraps it with the transform on the write side.

## Test plan
- FIPS-197 vector: i_block = 7ad5fda789ef4e272bca100b3d9ff59f, tag 3, o_ready = 1 -> next cycle o_block = 7a9f102789d5f50b2beffd9f3dca4ea7, o_tag = 3, o_valid = 1.
- Index pattern: i_block = 000102030405060708090a0b0c0d0e0f -> o_block = 000d0a0704010e0b0805020f0c090603.
- Backpressure: o_ready = 0 and 3 blocks offered back-to-back -> blocks 1 and 2 accepted, i_ready = 0 from the cycle after the second push, block 3 held. Then o_ready = 1 -> outputs appear in order 1, 2, 3 and i_ready recovers.
- Streaming: 20 consecutive blocks with o_ready = 1 -> 20 outputs on 20 consecutive cycles, each 1 cycle after its input, with tags in order.
- Random i_valid/o_ready toggling over 1000 blocks -> scoreboard matches a reference inv_shift_rows model exactly. Additionally, shift_rows(inv_shift_rows(x)) = x.
- Reset: assert rst_n low while FULL -> o_valid, o_block and o_tag go to 0 without waiting for a clk edge. After release, i_ready = 1 one edge later and no stale block ever appears.
